// File: rtl/com_pkg.sv
// Shared definitions for the com link: bag types, sync byte, CRC-8, error codes, FSM states.
package com_pkg;

    localparam logic [7:0] SYNC_DEF = 8'hA5;

    // Reserved bag types; every other 4-bit type is a legal bag.
    localparam logic [3:0] BAG_RSV0 = 4'h0;
    localparam logic [3:0] BAG_RSV4 = 4'h4;
    localparam logic [3:0] BAG_RSVB = 4'hB;
    localparam logic [3:0] BAG_RSVF = 4'hF;

    localparam logic [1:0] ERR_TYPE    = 2'd0;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_OVERRUN = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_HEAD,
        ST_CHK,
        ST_HOLD,
        ST_REL
    } com_state_t;

    function automatic logic bag_type_legal(input logic [3:0] t);
        return !(t == BAG_RSV0 || t == BAG_RSV4 || t == BAG_RSVB || t == BAG_RSVF);
    endfunction

    // CRC-8, poly 0x07, init 0, MSB first, no reflection, no final xor.
    function automatic logic [7:0] crc8_07(input logic [7:0] b);
        logic [7:0] c;
        c = b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/com_crc8.sv
// Combinational CRC-8 of a single header byte; shared with the transmit side.
module com_crc8
    import com_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] crc
);

    assign crc = crc8_07(data);

endmodule

// File: rtl/com_rx_chk.sv
// Receive checker for the com link: sync hunt, header/CRC check, fs/fd handshake,
// and classified, saturating error counting.
module com_rx_chk
    import com_pkg::*;
#(
    parameter logic [7:0] SYNC       = SYNC_DEF,
    parameter int         FD_TIMEOUT = 1024,
    parameter int         CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       com_rxd,
    output logic             fs,
    input  logic             fd,
    output logic [3:0]       btype,
    output logic [3:0]       bdata,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int TW = (FD_TIMEOUT > 1) ? $clog2(FD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(FD_TIMEOUT - 1);

    com_state_t  state;
    logic [7:0]  hdr;
    logic [7:0]  hdr_crc;
    logic [TW-1:0] timer;
    logic        is_sync;
    logic        tmo_hit;

    com_crc8 u_crc (
        .data (hdr),
        .crc  (hdr_crc)
    );

    assign is_sync = (com_rxd == SYNC);
    // FD_TIMEOUT of 0 disables the abort entirely.
    assign tmo_hit = (FD_TIMEOUT != 0) && (timer == TMO_LAST);

    // Frame FSM with registered bag outputs, error pulse and handshake timer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_HUNT;
            hdr      <= '0;
            fs       <= 1'b0;
            btype    <= '0;
            bdata    <= '0;
            err      <= 1'b0;
            err_code <= ERR_TYPE;
            timer    <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (is_sync) state <= ST_HEAD;
                end
                ST_HEAD: begin
                    // Header is taken unconditionally, even a second SYNC byte.
                    hdr <= com_rxd;
                    if (!bag_type_legal(com_rxd[7:4])) begin
                        err      <= 1'b1;
                        err_code <= ERR_TYPE;
                        state    <= ST_HUNT;
                    end else begin
                        state <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (com_rxd == hdr_crc) begin
                        btype <= hdr[7:4];
                        bdata <= hdr[3:0];
                        fs    <= 1'b1;
                        timer <= '0;
                        state <= ST_HOLD;
                    end else begin
                        err      <= 1'b1;
                        err_code <= ERR_CRC;
                        state    <= ST_HUNT;
                    end
                end
                ST_HOLD: begin
                    // fd beats timeout; timeout beats overrun when both land together.
                    if (fd) begin
                        fs    <= 1'b0;
                        state <= ST_REL;
                        if (is_sync) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVERRUN;
                        end
                    end else if (tmo_hit) begin
                        fs       <= 1'b0;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_HUNT;
                    end else begin
                        timer <= timer + 1'b1;
                        if (is_sync) begin
                            err      <= 1'b1;
                            err_code <= ERR_OVERRUN;
                        end
                    end
                end
                ST_REL: begin
                    if (is_sync) begin
                        err      <= 1'b1;
                        err_code <= ERR_OVERRUN;
                    end
                    if (!fd) state <= ST_HUNT;
                end
                default: state <= ST_HUNT;
            endcase
        end
    end

    // Saturating count of error pulses, trailing err by one cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (err && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_com_rx_chk.sv
// Directed bench for com_rx_chk: handshake, CRC/type/overrun/timeout errors, reset, saturation.
module tb_com_rx_chk;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] com_rxd;
    logic       fs;
    logic       fd;
    logic [3:0] btype;
    logic [3:0] bdata;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] err_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    com_rx_chk #(
        .SYNC       (8'hA5),
        .FD_TIMEOUT (16),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .com_rxd  (com_rxd),
        .fs       (fs),
        .fd       (fd),
        .btype    (btype),
        .bdata    (bdata),
        .err      (err),
        .err_code (err_code),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    // One clock edge; outputs are then settled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        com_rxd = b0; step();
        com_rxd = b1; step();
        com_rxd = b2; step();
        com_rxd = 8'h00;
    endtask

    initial begin
        rst = 1'b0; com_rxd = 8'h00; fd = 1'b0;
        step(); step();
        chk("rst_fs", fs, 0);
        chk("rst_btype", btype, 0);
        chk("rst_bdata", bdata, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_cnt", err_cnt, 0);
        rst = 1'b1;
        step();

        // 1: good frame, fd two cycles after fs
        send3(8'hA5, 8'h15, 8'h6B);
        chk("t1_fs", fs, 1);
        chk("t1_btype", btype, 1);
        chk("t1_bdata", bdata, 5);
        chk("t1_err", err, 0);
        step();
        chk("t1_fs_hold", fs, 1);
        fd = 1'b1; step();
        chk("t1_fs_drop", fs, 0);
        chk("t1_noerr", err, 0);
        fd = 1'b0; step();
        chk("t1_cnt", err_cnt, 0);

        // 2: bad CRC, then the corrected frame
        send3(8'hA5, 8'h55, 8'hAD);
        chk("t2_err", err, 1);
        chk("t2_code", err_code, 1);
        chk("t2_fs", fs, 0);
        step();
        chk("t2_err_clr", err, 0);
        chk("t2_code_hold", err_code, 1);
        chk("t2_cnt", err_cnt, 1);
        send3(8'hA5, 8'h55, 8'hAC);
        chk("t2_fs", fs, 1);
        chk("t2_btype", btype, 5);
        chk("t2_bdata", bdata, 5);
        fd = 1'b1; step();
        chk("t2_fs_drop", fs, 0);
        fd = 1'b0; step();

        // 3: illegal type 4, trailing byte ignored, next frame accepted
        com_rxd = 8'hA5; step();
        com_rxd = 8'h45; step();
        chk("t3_err", err, 1);
        chk("t3_code", err_code, 0);
        com_rxd = 8'h6B; step();
        chk("t3_err_clr", err, 0);
        chk("t3_fs", fs, 0);
        chk("t3_cnt", err_cnt, 2);
        send3(8'hA5, 8'h15, 8'h6B);
        chk("t3_fs_ok", fs, 1);
        chk("t3_btype", btype, 1);
        fd = 1'b1; step();
        fd = 1'b0; step();
        chk("t3_fs_drop", fs, 0);

        // 4: fd never comes; fs high exactly 16 cycles then timeout
        send3(8'hA5, 8'h55, 8'hAC);
        chk("t4_fs_c1", fs, 1);
        for (int i = 2; i <= 16; i++) begin
            step();
            chk($sformatf("t4_fs_c%0d", i), fs, 1);
            chk($sformatf("t4_noerr_c%0d", i), err, 0);
        end
        step();
        chk("t4_fs_drop", fs, 0);
        chk("t4_err", err, 1);
        chk("t4_code", err_code, 3);
        step();
        chk("t4_cnt", err_cnt, 3);

        // 5: overrun SYNC while fs high
        send3(8'hA5, 8'h15, 8'h6B);
        chk("t5_fs", fs, 1);
        com_rxd = 8'hA5; step();
        com_rxd = 8'h00;
        chk("t5_err", err, 1);
        chk("t5_code", err_code, 2);
        chk("t5_fs_hold", fs, 1);
        chk("t5_btype", btype, 1);
        chk("t5_bdata", bdata, 5);
        step();
        chk("t5_cnt", err_cnt, 4);
        fd = 1'b1; step();
        chk("t5_fs_drop", fs, 0);
        fd = 1'b0; step();

        // 6: reset during HOLD, then counter saturation
        send3(8'hA5, 8'h55, 8'hAC);
        chk("t6_fs", fs, 1);
        rst = 1'b0; step();
        chk("t6_rst_fs", fs, 0);
        chk("t6_rst_cnt", err_cnt, 0);
        chk("t6_rst_err", err, 0);
        rst = 1'b1; step();
        for (int i = 0; i < 255; i++) send3(8'hA5, 8'h55, 8'h00);
        step();
        chk("t6_cnt_255", err_cnt, 255);
        for (int i = 0; i < 45; i++) send3(8'hA5, 8'h55, 8'h00);
        step(); step();
        chk("t6_cnt_sat", err_cnt, 255);
        chk("t6_fs_end", fs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
